sram_arbiter: RTL and testbench

- Time-multiplexes the single frame-buffer SRAM port between the fill engine (f_) and the alpha blender (a_).
- Replaces static enable-based steering with a req/grant/done handshake, fairness, and access-length sequencing.
- Sits between both engines and the SRAM controller. Outputs drive the SRAM read_enable/write_enable/address/write_data directly.

---
 rtl/gpu_sram_pkg.sv | 51 +++++
 rtl/sram_arbiter_if.sv | 50 +++++
 rtl/sram_acc_timer.sv | 34 +++
 rtl/sram_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_sram_pkg.sv
// -----------------------------------------------------------------------------
// gpu_sram_pkg
// Shared types for the frame-buffer SRAM path. The SRAM controller and the
// arbiter both import this package.
//   owner_t     : which engine owns the SRAM port (fill or alpha)
//   sram_cmd_t  : one SRAM command (read/write enables, address, line data)
//   arb_state_t : arbiter sequencing states
//   make_cmd()  : builds a command and resolves a read+write request to a write
// -----------------------------------------------------------------------------
package gpu_sram_pkg;

    localparam int SRAM_ADDR_W = 24;
    localparam int SRAM_DATA_W = 1536;   // one 64-pixel x 24-bit line

    typedef enum logic {
        OWN_FILL  = 1'b0,
        OWN_ALPHA = 1'b1
    } owner_t;

    typedef struct packed {
        logic                   re;
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } sram_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GNT_F  = 3'd1,
        ST_GNT_A  = 3'd2,
        ST_DONE_F = 3'd3,
        ST_DONE_A = 3'd4
    } arb_state_t;

    // A request with both enables set is treated as a write; the SRAM must
    // never see both strobes together.
    function automatic sram_cmd_t make_cmd(
        input logic                   re,
        input logic                   we,
        input logic [SRAM_ADDR_W-1:0] addr,
        input logic [SRAM_DATA_W-1:0] wdata
    );
        sram_cmd_t cmd;
        cmd.re    = re & ~we;
        cmd.we    = we;
        cmd.addr  = addr;
        cmd.wdata = wdata;
        return cmd;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Bundles the two engine handshakes (fill f_*, alpha a_*) and the SRAM command
// outputs of the arbiter.
//   slave  modport : arbiter view (engine requests in, grants/done/SRAM out)
//   master modport : engine/test view (requests out, grants/done/SRAM in)
// -----------------------------------------------------------------------------
interface sram_arbiter_if
    import gpu_sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
);
    // fill engine
    logic              f_req;
    logic              f_read_enable;
    logic              f_write_enable;
    logic [ADDR_W-1:0] f_address;
    logic [DATA_W-1:0] f_write_data;
    logic              f_grant;
    logic              f_done;
    // alpha blender
    logic              a_req;
    logic              a_read_enable;
    logic              a_write_enable;
    logic [ADDR_W-1:0] a_address;
    logic [DATA_W-1:0] a_write_data;
    logic              a_grant;
    logic              a_done;
    // SRAM controller side
    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;

    modport slave (
        input  f_req, f_read_enable, f_write_enable, f_address, f_write_data,
        input  a_req, a_read_enable, a_write_enable, a_address, a_write_data,
        output f_grant, f_done, a_grant, a_done,
        output read_enable, write_enable, address, write_data
    );

    modport master (
        output f_req, f_read_enable, f_write_enable, f_address, f_write_data,
        output a_req, a_read_enable, a_write_enable, a_address, a_write_data,
        input  f_grant, f_done, a_grant, a_done,
        input  read_enable, write_enable, address, write_data
    );

endinterface

// File: rtl/sram_acc_timer.sv
// -----------------------------------------------------------------------------
// sram_acc_timer
// Loadable 4-bit down-counter with a zero flag; times how long an SRAM access
// is held. Load has priority over decrement; the count stops at zero.
//   clk, n_rst : clock, asynchronous active-low reset (count -> 0)
//   load       : load load_val
//   load_val   : value to load (cycles remaining - 1)
//   dec        : decrement when non-zero
//   zero       : count is zero
// -----------------------------------------------------------------------------
module sram_acc_timer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != 4'd0)) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Time-multiplexes the frame-buffer SRAM port between the fill engine (f_*)
// and the alpha blender (a_*) with a req/grant/done handshake.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : sram_arbiter_if.slave (engine requests, grants, one-cycle done
//                pulses, and the SRAM read/write enables, address, data)
// Sequence per access: IDLE -> GNT_x (ACC_CYCLES cycles, command driven from a
// latch captured at grant) -> DONE_x (one-cycle done pulse) -> IDLE.
// Ties are resolved round-robin against the last owner; defining
// SRAM_ARB_ALPHA_PRIO_EN makes alpha win every tie instead.
// -----------------------------------------------------------------------------
module sram_arbiter
    import gpu_sram_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int ACC_CYCLES = 2            // 1..15
) (
    input logic           clk,
    input logic           n_rst,
    sram_arbiter_if.slave bus
);

    localparam logic [3:0] ACC_LOAD = 4'(ACC_CYCLES - 1);

    arb_state_t state_reg;
    owner_t     last_owner_reg;
    sram_cmd_t  cmd_reg;
    logic       f_grant_reg;
    logic       a_grant_reg;
    logic       f_done_reg;
    logic       a_done_reg;

    logic       any_req;
    logic       pick_fill;
    logic       timer_load;
    logic       timer_dec;
    logic       timer_zero;
    sram_cmd_t  f_cmd;
    sram_cmd_t  a_cmd;

    assign any_req = bus.f_req | bus.a_req;

`ifdef SRAM_ARB_ALPHA_PRIO_EN
    // Fixed priority: fill only gets the port when alpha is not asking.
    assign pick_fill = bus.f_req & ~bus.a_req;
`else
    // Round-robin: on a tie, the engine that did not own the last access wins.
    assign pick_fill = bus.f_req & (~bus.a_req | (last_owner_reg == OWN_ALPHA));
`endif

    assign f_cmd = make_cmd(bus.f_read_enable, bus.f_write_enable,
                            SRAM_ADDR_W'(bus.f_address),
                            SRAM_DATA_W'(bus.f_write_data));
    assign a_cmd = make_cmd(bus.a_read_enable, bus.a_write_enable,
                            SRAM_ADDR_W'(bus.a_address),
                            SRAM_DATA_W'(bus.a_write_data));

    // Timer is armed on the same edge that enters GNT_x, so its first GNT
    // cycle already shows ACC_CYCLES-1 remaining.
    assign timer_load = (state_reg == ST_IDLE) & any_req;
    assign timer_dec  = (state_reg == ST_GNT_F) | (state_reg == ST_GNT_A);

    sram_acc_timer u_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (timer_load),
        .load_val (ACC_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    // The command latch doubles as the SRAM output register: it is loaded on
    // grant and cleared when the access ends, so outputs are zero elsewhere.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= ST_IDLE;
            last_owner_reg <= OWN_ALPHA;
            cmd_reg        <= '0;
            f_grant_reg    <= 1'b0;
            a_grant_reg    <= 1'b0;
            f_done_reg     <= 1'b0;
            a_done_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        if (pick_fill) begin
                            state_reg   <= ST_GNT_F;
                            f_grant_reg <= 1'b1;
                            cmd_reg     <= f_cmd;
                        end else begin
                            state_reg   <= ST_GNT_A;
                            a_grant_reg <= 1'b1;
                            cmd_reg     <= a_cmd;
                        end
                    end
                end
                ST_GNT_F: begin
                    if (timer_zero) begin
                        state_reg   <= ST_DONE_F;
                        f_grant_reg <= 1'b0;
                        f_done_reg  <= 1'b1;
                        cmd_reg     <= '0;
                    end
                end
                ST_GNT_A: begin
                    if (timer_zero) begin
                        state_reg   <= ST_DONE_A;
                        a_grant_reg <= 1'b0;
                        a_done_reg  <= 1'b1;
                        cmd_reg     <= '0;
                    end
                end
                ST_DONE_F: begin
                    state_reg      <= ST_IDLE;
                    f_done_reg     <= 1'b0;
                    last_owner_reg <= OWN_FILL;
                end
                ST_DONE_A: begin
                    state_reg      <= ST_IDLE;
                    a_done_reg     <= 1'b0;
                    last_owner_reg <= OWN_ALPHA;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    f_grant_reg <= 1'b0;
                    a_grant_reg <= 1'b0;
                    f_done_reg  <= 1'b0;
                    a_done_reg  <= 1'b0;
                    cmd_reg     <= '0;
                end
            endcase
        end
    end

    assign bus.f_grant      = f_grant_reg;
    assign bus.a_grant      = a_grant_reg;
    assign bus.f_done       = f_done_reg;
    assign bus.a_done       = a_done_reg;
    assign bus.read_enable  = cmd_reg.re;
    assign bus.write_enable = cmd_reg.we;
    assign bus.address      = ADDR_W'(cmd_reg.addr);
    assign bus.write_data   = DATA_W'(cmd_reg.wdata);

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Directed scenarios followed by randomized request traffic for sram_arbiter.
// The reference model works per access: it decides the owner from the pending
// requests and the previous owner, then expects ACC grant cycles carrying the
// command captured at grant time, one done cycle, and quiet outputs otherwise.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
    import gpu_sram_pkg::*;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 1536;
    localparam int ACC    = 2;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_CYCLES(ACC)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    typedef struct {
        logic              re;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } tcmd_t;

    int     checks = 0;
    int     errors = 0;
    int     acc_no = 0;
    tcmd_t  f_c, a_c;
    logic   f_pend, a_pend;
    owner_t last_own;

    function automatic tcmd_t rand_cmd();
        tcmd_t c;
        c.re   = 1'($urandom_range(1));
        c.we   = 1'($urandom_range(1));
        c.addr = ADDR_W'($urandom);
        for (int i = 0; i < DATA_W / 32; i++) c.wdata[i*32 +: 32] = $urandom;
        return c;
    endfunction

    task automatic drive();
        bus.f_req          = f_pend;
        bus.f_read_enable  = f_c.re;
        bus.f_write_enable = f_c.we;
        bus.f_address      = f_c.addr;
        bus.f_write_data   = f_c.wdata;
        bus.a_req          = a_pend;
        bus.a_read_enable  = a_c.re;
        bus.a_write_enable = a_c.we;
        bus.a_address      = a_c.addr;
        bus.a_write_data   = a_c.wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_addr(input string tag, input logic [ADDR_W-1:0] got,
                              input logic [ADDR_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_data(input string tag, input logic [DATA_W-1:0] got,
                              input logic [DATA_W-1:0] exp);
        logic [127:0] g_lo, e_lo;
        g_lo = got[127:0];
        e_lo = exp[127:0];
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed low128 %h expected low128 %h", tag, g_lo, e_lo);
        end
    endtask

    task automatic check_all(input string tag, input logic efg, input logic eag,
                             input logic efd, input logic ead, input logic ere,
                             input logic ewe, input logic [ADDR_W-1:0] eaddr,
                             input logic [DATA_W-1:0] ewd);
        check_bit({tag, ".f_grant"}, bus.f_grant, efg);
        check_bit({tag, ".a_grant"}, bus.a_grant, eag);
        check_bit({tag, ".f_done"}, bus.f_done, efd);
        check_bit({tag, ".a_done"}, bus.a_done, ead);
        check_bit({tag, ".read_enable"}, bus.read_enable, ere);
        check_bit({tag, ".write_enable"}, bus.write_enable, ewe);
        check_addr({tag, ".address"}, bus.address, eaddr);
        check_data({tag, ".write_data"}, bus.write_data, ewd);
    endtask

    task automatic check_quiet(input string tag);
        check_all(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Owner chosen from the pending requests and the previous owner.
    function automatic owner_t predict();
        if (f_pend && a_pend) begin
`ifdef SRAM_ARB_ALPHA_PRIO_EN
            return OWN_ALPHA;
`else
            return (last_own == OWN_ALPHA) ? OWN_FILL : OWN_ALPHA;
`endif
        end
        return f_pend ? OWN_FILL : OWN_ALPHA;
    endfunction

    // One full access by `who`. Entered with the DUT idle (from_done=0) or
    // sitting in its done cycle (from_done=1, one idle cycle comes first).
    task automatic serve(input bit from_done, input owner_t who);
        tcmd_t c;
        logic  isf, ere, ewe;
        if (from_done) begin
            step();
            check_quiet($sformatf("acc%0d.idle", acc_no));
        end
        isf = (who == OWN_FILL);
        c   = isf ? f_c : a_c;
        ere = c.re & ~c.we;          // write wins over read
        ewe = c.we;
        for (int k = 0; k < ACC; k++) begin
            step();
            check_all($sformatf("acc%0d.gnt%0d", acc_no, k), isf, ~isf, 1'b0, 1'b0,
                      ere, ewe, c.addr, c.wdata);
            // Owner moves on to a new command (and may drop its request)
            // while the captured one is still on the SRAM.
            if (isf) f_c = rand_cmd(); else a_c = rand_cmd();
            if ($urandom_range(3) == 0) begin
                if (isf) f_pend = 1'b0; else a_pend = 1'b0;
            end
            drive();
        end
        step();
        check_all($sformatf("acc%0d.done", acc_no), 1'b0, 1'b0, isf, ~isf,
                  1'b0, 1'b0, '0, '0);
        if (isf) f_pend = 1'b0; else a_pend = 1'b0;
        drive();
        last_own = who;
        $display("access %0d: owner=%s re=%b we=%b addr=%h", acc_no,
                 isf ? "fill" : "alpha", c.re, c.we, c.addr);
        acc_no++;
    endtask

    task automatic do_reset();
        n_rst  = 1'b0;
        f_pend = 1'b0;
        a_pend = 1'b0;
        f_c    = rand_cmd();
        a_c    = rand_cmd();
        drive();
        repeat (2) @(posedge clk);
        #1;
        n_rst    = 1'b1;
        last_own = OWN_ALPHA;
    endtask

    initial begin
        owner_t exp_own;
        bit     from_done;

        // Reset state
        do_reset();
        check_quiet("reset");

        // Full fill write to 0x000010: grant in cycle 1, done in cycle 3
        f_c.re = 1'b0; f_c.we = 1'b1; f_c.addr = 24'h000010;
        f_pend = 1'b1;
        drive();
        serve(1'b0, OWN_FILL);

        // Same write again, reset asserted during the grant
        f_c.re = 1'b0; f_c.we = 1'b1; f_c.addr = 24'h000010;
        f_pend = 1'b1;
        drive();
        step();
        check_quiet("mid.idle");
        step();
        check_all("mid.gnt0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000010, f_c.wdata);
        #1 n_rst = 1'b0;
        #1 check_quiet("mid.async_rst");
        f_pend = 1'b0;
        drive();
        step();
        check_quiet("mid.no_done1");
        step();
        check_quiet("mid.no_done2");
        n_rst    = 1'b1;
        last_own = OWN_ALPHA;
        step();
        check_quiet("mid.after_rst");

        // Sustained contention from reset: F,A,F,A,F,A (alpha only with priority)
        do_reset();
        f_pend = 1'b1;
        a_pend = 1'b1;
        drive();
        for (int i = 0; i < 6; i++) begin
`ifdef SRAM_ARB_ALPHA_PRIO_EN
            exp_own = OWN_ALPHA;
`else
            exp_own = (i % 2 == 0) ? OWN_FILL : OWN_ALPHA;
`endif
            serve(i != 0, exp_own);
            f_pend = 1'b1;       // both engines keep asking
            a_pend = 1'b1;
            drive();
        end

        // Command stability: alpha read at 0x0ABCDE, inputs change after grant
        do_reset();
        a_c.re = 1'b1; a_c.we = 1'b0; a_c.addr = 24'h0ABCDE;
        a_pend = 1'b1;
        drive();
        serve(1'b0, OWN_ALPHA);

        // Illegal command: both enables -> write only
        do_reset();
        f_c.re = 1'b1; f_c.we = 1'b1;
        f_pend = 1'b1;
        drive();
        serve(1'b0, OWN_FILL);

        // Null command: no enables, still sequenced
        do_reset();
        a_c.re = 1'b0; a_c.we = 1'b0;
        a_pend = 1'b1;
        drive();
        serve(1'b0, OWN_ALPHA);

        // Randomized traffic
        from_done = 1'b1;
        for (int r = 0; r < 60; r++) begin
            if (!f_pend && ($urandom_range(1) == 1)) begin
                f_pend = 1'b1;
                f_c    = rand_cmd();
            end
            if (!a_pend && ($urandom_range(1) == 1)) begin
                a_pend = 1'b1;
                a_c    = rand_cmd();
            end
            drive();
            if (!f_pend && !a_pend) begin
                step();
                check_quiet($sformatf("rnd%0d.idle", r));
                from_done = 1'b0;
            end else begin
                serve(from_done, predict());
                from_done = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
